board_scan_ctrl: RTL

BOARD_SCAN_CTRL -- requirements
Module: board_scan_ctrl

---
 rtl/board_scan_ctrl_pkg.sv | 42 ++++
 rtl/board_scan_ctrl_if.sv | 31 +++
 rtl/board_scan_ctrl_bit_select.sv | 32 +++
 rtl/board_scan_ctrl.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/board_scan_ctrl_pkg.sv
// Shared game definitions: level encodings, board sizes, scan FSM states and
// the pass limit used by the board scan controller.
package board_scan_ctrl_pkg;

  localparam logic [1:0] LVL_NONE   = 2'd0;
  localparam logic [1:0] LVL_EASY   = 2'd1;
  localparam logic [1:0] LVL_MEDIUM = 2'd2;
  localparam logic [1:0] LVL_HARD   = 2'd3;

  localparam logic [4:0] N_EASY   = 5'd8;
  localparam logic [4:0] N_MEDIUM = 5'd10;
  localparam logic [4:0] N_HARD   = 5'd16;

  localparam int         MAX_PASSES = 32;
  // Index of the last pass a sequence may run (passes are numbered from 0).
  localparam logic [4:0] LAST_PASS  = 5'(MAX_PASSES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Maps are indexed [y][x].
  typedef logic [7:0][7:0]   map_easy_t;
  typedef logic [9:0][9:0]   map_medium_t;
  typedef logic [15:0][15:0] map_hard_t;

  // Board edge length for a level; 0 means no game.
  function automatic logic [4:0] board_size(input logic [1:0] level);
    logic [4:0] n;
    case (level)
      LVL_EASY:   n = N_EASY;
      LVL_MEDIUM: n = N_MEDIUM;
      LVL_HARD:   n = N_HARD;
      default:    n = 5'd0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/board_scan_ctrl_if.sv
// Game-side bus of the scan controller: level/start/maps in, scan
// coordinates and sequence status out.
interface board_scan_ctrl_if;
  import board_scan_ctrl_pkg::*;

  logic [1:0]  level;
  logic        start;
  logic [8:0]  mine_total;
  map_easy_t   defuse_arr_easy_in;
  map_medium_t defuse_arr_medium_in;
  map_hard_t   defuse_arr_hard_in;
  logic [4:0]  arr_x_refresh;
  logic [4:0]  arr_y_refresh;
  logic        busy;
  logic        done;
  logic        win;
  logic [8:0]  defused_cnt;

  modport master (
    output level, start, mine_total,
    output defuse_arr_easy_in, defuse_arr_medium_in, defuse_arr_hard_in,
    input  arr_x_refresh, arr_y_refresh, busy, done, win, defused_cnt
  );

  modport slave (
    input  level, start, mine_total,
    input  defuse_arr_easy_in, defuse_arr_medium_in, defuse_arr_hard_in,
    output arr_x_refresh, arr_y_refresh, busy, done, win, defused_cnt
  );

endinterface

// File: rtl/board_scan_ctrl_bit_select.sv
// Picks the defused-map bit at (x, y) from the map belonging to the level.
// Coordinates outside the board read as 0.
module board_bit_select
  import board_scan_ctrl_pkg::*;
(
  input  logic [1:0]  level_i,
  input  logic [4:0]  x_i,
  input  logic [4:0]  y_i,
  input  map_easy_t   easy_i,
  input  map_medium_t medium_i,
  input  map_hard_t   hard_i,
  output logic        bit_o
);

  // Level-indexed map lookup with bounds guard.
  always_comb begin
    bit_o = 1'b0;
    case (level_i)
      LVL_EASY:
        if (x_i < N_EASY && y_i < N_EASY)
          bit_o = easy_i[y_i[2:0]][x_i[2:0]];
      LVL_MEDIUM:
        if (x_i < N_MEDIUM && y_i < N_MEDIUM)
          bit_o = medium_i[y_i[3:0]][x_i[3:0]];
      LVL_HARD:
        if (x_i < N_HARD && y_i < N_HARD)
          bit_o = hard_i[y_i[3:0]][x_i[3:0]];
      default: bit_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/board_scan_ctrl.sv
// Repeatedly scans the selected board, counting defused fields per pass,
// until two consecutive passes agree or the pass limit is hit, then reports
// the count and whether the game is won.
module board_scan_ctrl
  import board_scan_ctrl_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  board_scan_ctrl_if.slave bus
);

  state_e     state_q, state_d;
  logic [1:0] level_q, level_d;
  logic [4:0] x_q, x_d, y_q, y_d;
  logic [8:0] acc_q, acc_d;
  logic [8:0] prev_q, prev_d;
  logic [8:0] cnt_q, cnt_d;
  logic [4:0] pass_q, pass_d;
  logic       win_q, win_d;

  logic [4:0] n_act;
  logic [4:0] n_last;
  logic [9:0] board_area;
  logic       map_bit;
  logic       start_ok;
  logic       level_chg;
  logic       last_coord;
  logic       another_pass;
  logic       win_hit;

  // The level latched at start drives the scan; any later difference on the
  // input while busy is treated as an abort.
  assign n_act      = board_size(level_q);
  assign n_last     = n_act - 5'd1;
  assign board_area = {5'd0, n_act} * {5'd0, n_act};
  assign start_ok   = bus.start && (bus.level != LVL_NONE);
  assign level_chg  = (bus.level != level_q);
  assign last_coord = (x_q == n_last) && (y_q == n_last);
  // Pass 0 is always followed by another pass so there is something to compare.
  assign another_pass = ((pass_q == 5'd0) || (acc_q != prev_q)) && (pass_q < LAST_PASS);
  assign win_hit      = ({1'b0, acc_q} + {1'b0, bus.mine_total}) == board_area;

  board_bit_select u_bit_select (
    .level_i  (level_q),
    .x_i      (x_q),
    .y_i      (y_q),
    .easy_i   (bus.defuse_arr_easy_in),
    .medium_i (bus.defuse_arr_medium_in),
    .hard_i   (bus.defuse_arr_hard_in),
    .bit_o    (map_bit)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (start_ok) state_d = SCAN;
      SCAN: begin
        if (level_chg)       state_d = IDLE;
        else if (last_coord) state_d = CHECK;
      end
      CHECK: begin
        if (level_chg)         state_d = IDLE;
        else if (another_pass) state_d = SCAN;
        else                   state_d = DONE;
      end
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs decoded from the current state.
  always_comb begin
    bus.busy = (state_q == SCAN) || (state_q == CHECK);
    bus.done = (state_q == DONE);
  end

  // Datapath next-state: coordinate walk, pass accumulation and pass check.
  // Coordinates return to 0 whenever SCAN is left, so they read 0 elsewhere.
  always_comb begin
    level_d = level_q;
    x_d     = x_q;
    y_d     = y_q;
    acc_d   = acc_q;
    prev_d  = prev_q;
    cnt_d   = cnt_q;
    pass_d  = pass_q;
    win_d   = win_q;
    case (state_q)
      IDLE: begin
        if (start_ok) begin
          level_d = bus.level;
          x_d     = 5'd0;
          y_d     = 5'd0;
          acc_d   = 9'd0;
          prev_d  = 9'd0;
          pass_d  = 5'd0;
          win_d   = 1'b0;
        end
      end
      SCAN: begin
        if (level_chg) begin
          x_d   = 5'd0;
          y_d   = 5'd0;
          win_d = 1'b0;
        end else begin
          acc_d = acc_q + {8'd0, map_bit};
          if (x_q == n_last) begin
            x_d = 5'd0;
            y_d = (y_q == n_last) ? 5'd0 : y_q + 5'd1;
          end else begin
            x_d = x_q + 5'd1;
          end
        end
      end
      CHECK: begin
        if (level_chg) begin
          win_d = 1'b0;
        end else begin
          cnt_d  = acc_q;
          prev_d = acc_q;
          if (another_pass) begin
            pass_d = pass_q + 5'd1;
            acc_d  = 9'd0;
          end else begin
            win_d = win_hit;
          end
        end
      end
      default: ;
    endcase
  end

  // Datapath registers; reset clears everything, including mid-scan.
  always_ff @(posedge clk) begin
    if (rst) begin
      level_q <= LVL_NONE;
      x_q     <= 5'd0;
      y_q     <= 5'd0;
      acc_q   <= 9'd0;
      prev_q  <= 9'd0;
      cnt_q   <= 9'd0;
      pass_q  <= 5'd0;
      win_q   <= 1'b0;
    end else begin
      level_q <= level_d;
      x_q     <= x_d;
      y_q     <= y_d;
      acc_q   <= acc_d;
      prev_q  <= prev_d;
      cnt_q   <= cnt_d;
      pass_q  <= pass_d;
      win_q   <= win_d;
    end
  end

  assign bus.arr_x_refresh = x_q;
  assign bus.arr_y_refresh = y_q;
  assign bus.defused_cnt   = cnt_q;
  assign bus.win           = win_q;

endmodule
